// File: rtl/filter_seq.sv
// Front-end controller for the 3-parallel FIR core: loads the coefficient vector
// over a byte handshake, packs the sample stream into triples and sequences reloads.
module filter_seq #(
   parameter int NB       = 8,
   parameter int NT       = 10,
   parameter int PIPE_LAT = 6
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 CFG_VALID,
   input  logic [NB-1:0]        CFG_DATA,
   output logic                 CFG_READY,
   input  logic                 S_VALID,
   input  logic [NB-1:0]        S_DATA,
   output logic                 S_READY,
   input  logic                 RELOAD,
   output logic [(NT+1)*NB-1:0] B,
   output logic [NB-1:0]        DIN0,
   output logic [NB-1:0]        DIN1,
   output logic [NB-1:0]        DIN2,
   output logic                 VIN,
   output logic                 BUSY
);
   localparam int IW = $clog2(NT+1);
   localparam int DW = $clog2(PIPE_LAT+1);

   typedef enum logic [1:0] {LOAD, RUN, FLUSH, DRAIN} state_t;

   state_t              state, state_nx;
   logic [IW-1:0]       idx;
   logic [DW-1:0]       drain_cnt;
   logic [1:0]          p, p_nx;
   logic [NT*NB-1:0]    shadow;
   logic [1:0][NB-1:0]  hold;
   logic                cfg_xfer, s_xfer, last_byte;

   always_ff @(posedge CLK) begin
      if (!RST_n) state <= LOAD;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cfg_xfer  = CFG_VALID && CFG_READY;
      s_xfer    = S_VALID && S_READY;
      last_byte = cfg_xfer && (idx == IW'(NT));
      p_nx      = p;
      if (s_xfer) p_nx = (p == 2'd2) ? 2'd0 : p + 2'd1;
      case (state)
         LOAD:    if (last_byte) state_nx = RUN;
         // the phase after this edge decides whether a partial triple must be flushed
         RUN:     if (RELOAD) state_nx = (p_nx != 2'd0) ? FLUSH : DRAIN;
         FLUSH:   state_nx = DRAIN;
         DRAIN:   if (drain_cnt == DW'(PIPE_LAT-1)) state_nx = LOAD;
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         idx       <= '0;
         drain_cnt <= '0;
         p         <= '0;
         shadow    <= '0;
         hold      <= '0;
         B         <= '0;
         DIN0      <= '0;
         DIN1      <= '0;
         DIN2      <= '0;
         VIN       <= 1'b0;
         CFG_READY <= 1'b0;
         S_READY   <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         CFG_READY <= (state_nx == LOAD);
         S_READY   <= (state_nx == RUN);
         BUSY      <= (state_nx == FLUSH) || (state_nx == DRAIN);
         VIN       <= 1'b0;
         drain_cnt <= (state == DRAIN && state_nx == DRAIN) ? drain_cnt + DW'(1) : '0;

         // bytes shift in MSB-first; the final byte commits the whole vector at once
         if (cfg_xfer) begin
            if (last_byte) begin
               B   <= {shadow, CFG_DATA};
               idx <= '0;
            end else begin
               shadow <= {shadow[(NT-1)*NB-1:0], CFG_DATA};
               idx    <= idx + IW'(1);
            end
         end

         if (s_xfer) begin
            p <= p_nx;
            if (p == 2'd2) begin
               DIN0 <= hold[0];
               DIN1 <= hold[1];
               DIN2 <= S_DATA;
               VIN  <= 1'b1;
            end else begin
               hold[p[0]] <= S_DATA;
            end
         end

         // only slot 0 is guaranteed filled here; p tells whether slot 1 is too
         if (state == FLUSH) begin
            DIN0 <= hold[0];
            DIN1 <= (p == 2'd2) ? hold[1] : '0;
            DIN2 <= '0;
            VIN  <= 1'b1;
            p    <= '0;
         end
      end
   end
endmodule
